// File: rtl/eq_pipe_pkg.sv
// Shared types and constants for the E = 5A+5B-4C+3D pipeline and its result collector.
package eq_pipe_pkg;

  localparam int EQ_LAT   = 3;
  localparam int EQ_DW    = 16;
  localparam int EQ_D     = 768;
  localparam int EQ_TAG_W = 4;

  typedef struct packed {
    logic [EQ_TAG_W-1:0] tag;
    logic [EQ_DW-1:0]    data;
  } eq_result_t;

endpackage

// File: rtl/eq_result_fifo.sv
// Synchronous FIFO of tagged results; pointers carry an extra MSB to tell full from empty.
module eq_result_fifo
  import eq_pipe_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = eq_result_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  item_t                    wdata,
  input  logic                     pop,
  output item_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  item_t       mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // NOTE: storage is cleared on reset so the head reads 0 before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/eq_result_collector.sv
// Collects valid E results from the equation pipeline into a tagged FIFO and
// back-pressures the pipeline so no result is dropped or captured twice.
module eq_result_collector
  import eq_pipe_pkg::*;
#(
  parameter int DW    = EQ_DW,
  parameter int LAT   = EQ_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = EQ_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DW-1:0]            e_in,
  output logic                     stall,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              total_count
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } result_t;

  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      total_q, total_d;
  logic             full, empty, push, pop;
  result_t          wr_item, head;

  // Stall only when a real result sits at the pipeline head; bubbles keep flowing.
  assign stall   = vld_q[LAT-1] & full;
  assign push    = vld_q[LAT-1] & ~stall;
  assign pop     = out_valid & out_ready;
  assign wr_item = '{tag: tag_q, data: e_in};

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    vld_d   = vld_q;
    tag_d   = tag_q;
    total_d = total_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
    end
    if (push) begin
      tag_d   = tag_q + TAG_W'(1);
      total_d = total_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      tag_q   <= '0;
      total_q <= '0;
    end else begin
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      total_q <= total_d;
    end
  end

  eq_result_fifo #(
    .DEPTH  (DEPTH),
    .item_t (result_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_item),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_valid   = ~empty;
  assign out_data    = head.data;
  assign out_tag     = head.tag;
  assign total_count = total_q;

endmodule

// File: tb/tb_eq_result_collector.sv
// Bench for eq_result_collector: drives a behavioural equation pipeline and
// checks every popped result against an end-to-end scoreboard.
module tb_eq_result_collector;
  import eq_pipe_pkg::*;

  localparam int DW    = 16;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   a = '0, b = '0, c = '0;
  logic [DW-1:0]   e_in;
  logic            stall, out_valid, out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]   fifo_count;
  logic [15:0]     total_count;

  always #5 clk = ~clk;

  eq_result_collector #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .e_in        (e_in),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .total_count (total_count)
  );

  function automatic logic [DW-1:0] eq_calc(input logic [DW-1:0] x, y, z);
    return DW'(5 * int'(x) + 5 * int'(y) - 4 * int'(z) + 3 * EQ_D);
  endfunction

  // Behavioural equation pipeline, frozen while stall is high.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } op_t;

  op_t pipe [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= '{v: in_valid, a: a, b: b, c: c};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign e_in = eq_calc(pipe[LAT-1].a, pipe[LAT-1].b, pipe[LAT-1].c);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } res_t;

  res_t             exp_q [$];
  res_t             pop_log [$];
  int               occ = 0;
  int               acc_cnt = 0;
  int               stall_hi = 0;
  logic [15:0]      cap_cnt = '0;
  logic [TAG_W-1:0] tag_m = '0;
  logic             last_stall = 1'b0;

  // Scoreboard: results leave in acceptance order with tags counting modulo 2^TAG_W.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ = 0; acc_cnt = 0; cap_cnt = '0; tag_m = '0; last_stall = 1'b0;
    end else begin
      logic cap, pp;
      check("stall", 32'(stall), 32'(pipe[LAT-1].v && occ == DEPTH));
      check("fifo_count", 32'(fifo_count), 32'(occ));
      check("out_valid", 32'(out_valid), 32'(occ != 0));
      check("total_count", 32'(total_count), 32'(cap_cnt));
      if (out_valid && out_ready) begin
        pop_log.push_back('{tag: out_tag, data: out_data});
        if (exp_q.size() == 0) check("pop_unexpected", 32'(out_valid), 32'd0);
        else begin
          check("out_data", 32'(out_data), 32'(exp_q[0].data));
          check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && !stall) begin
        exp_q.push_back('{tag: tag_m, data: eq_calc(a, b, c)});
        tag_m++;
        acc_cnt++;
      end
      cap = pipe[LAT-1].v && !stall;
      pp  = (occ != 0) && out_ready;
      occ = occ + int'(cap) - int'(pp);
      if (cap) cap_cnt++;
      if (stall) stall_hi++;
      last_stall = stall;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic v, input logic [DW-1:0] x, y, z);
    int guard = 0;
    in_valid = v; a = x; b = y; c = z;
    @(negedge clk);
    while (stall && guard < 64) begin guard++; @(negedge clk); end
    if (guard >= 64) check("send_timeout", 32'(stall), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    pop_log.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_at, hi_cnt;
    logic [DW-1:0] seen_data;
    logic [TAG_W-1:0] seen_tag;
    int exp_d [3];
    exp_d = '{2310, 2434, 2304};

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_total", 32'(total_count), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single op: out_valid pulses once, four edges after in_valid
    out_ready = 1'b1;
    in_valid = 1'b1; a = 1; b = 1; c = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen_at = -1; hi_cnt = 0; seen_data = '0; seen_tag = '1;
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (seen_at < 0) begin seen_at = k; seen_data = out_data; seen_tag = out_tag; end
        hi_cnt++;
      end
    end
    check("lat_edge", 32'(seen_at), 4);
    check("lat_pulses", 32'(hi_cnt), 1);
    check("single_data", 32'(seen_data), 2310);
    check("single_tag", 32'(seen_tag), 0);
    check("single_total", 32'(total_count), 1);

    // Back-to-back ops
    do_reset();
    stall_hi = 0;
    out_ready = 1'b1;
    send(1, 1, 1, 1);
    send(1, 10, 20, 5);
    send(1, 0, 0, 0);
    wait_cycles(8);
    check("b2b_count", 32'(pop_log.size()), 3);
    for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
      check("b2b_data", 32'(pop_log[i].data), 32'(exp_d[i]));
      check("b2b_tag", 32'(pop_log[i].tag), 32'(i));
    end
    check("b2b_no_stall", 32'(stall_hi), 0);

    // Fill the FIFO with the consumer stopped, then release one pop
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 10; b = 20; c = 5;
    wait_cycles(12);
    check("fill_count", 32'(fifo_count), 4);
    check("fill_stall", 32'(stall), 1);
    out_ready = 1'b1;
    wait_cycles(1);
    out_ready = 1'b0;
    wait_cycles(3);
    check("one_pop_count", 32'(pop_log.size()), 1);
    check("one_pop_fifo", 32'(fifo_count), 4);
    check("one_pop_stall", 32'(stall), 1);
    check("one_pop_total", 32'(total_count), 5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_cycles(15);
    check("fill_drain_total", 32'(total_count), 8);
    check("fill_drain_pops", 32'(pop_log.size()), 8);
    for (int i = 0; i < pop_log.size(); i++)
      check("fill_tag_seq", 32'(pop_log[i].tag), 32'(i));

    // Full FIFO with bubbles between ops
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1, DW'(i), DW'(2 * i), DW'(3));
      send(0, 0, 0, 0);
      send(0, 0, 0, 0);
    end
    check("bub_full_nostall", 32'(stall), 0);
    send(1, 7, 7, 7);
    wait_cycles(4);
    check("bub_fifo", 32'(fifo_count), 4);
    check("bub_stall", 32'(stall), 1);
    out_ready = 1'b1;
    wait_cycles(12);
    check("bub_total", 32'(total_count), 5);
    check("bub_pops", 32'(pop_log.size()), 5);

    // Reset with results buffered and in flight
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1, DW'(i + 3), 1, 2);
    wait_cycles(1);
    check("pre_rst_fifo", 32'(fifo_count), 3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_out_tag", 32'(out_tag), 0);
    check("mid_rst_fifo", 32'(fifo_count), 0);
    check("mid_rst_total", 32'(total_count), 0);
    check("mid_rst_stall", 32'(stall), 0);
    pop_log.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(1, 1, 1, 1);
    wait_cycles(8);
    check("post_rst_total", 32'(total_count), 1);
    check("post_rst_pops", 32'(pop_log.size()), 1);
    if (pop_log.size() > 0) begin
      check("post_rst_tag", 32'(pop_log[0].tag), 0);
      check("post_rst_data", 32'(pop_log[0].data), 2310);
    end

    // Randomised traffic with a stalling consumer; tags wrap past 2^TAG_W
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      if (!last_stall) begin
        in_valid = ($urandom_range(0, 2) != 0);
        a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_cycles(20);
    check("rand_fifo_empty", 32'(fifo_count), 0);
    check("rand_sb_empty", 32'(exp_q.size()), 0);
    check("rand_total", 32'(total_count), 32'(acc_cnt));
    check("rand_wrapped", 32'(acc_cnt > 16), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
